// File: rtl/nco_pkg.sv
// Shared types and defaults for the NCO output monitor.
package nco_pkg;

    localparam int NCO_W_DEF  = 20;
    localparam int NCO_CW_DEF = 32;
    localparam int NCO_NP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } nco_state_t;

    // A request for zero periods is measured as a single period.
    function automatic logic [NCO_NP_W-1:0] np_target(input logic [NCO_NP_W-1:0] np);
        return (np == '0) ? NCO_NP_W'(1) : np;
    endfunction

endpackage

// File: rtl/nco_mon_if.sv
// Sample stream, measurement request and result bundle of the NCO monitor.
interface nco_mon_if
    import nco_pkg::*;
#(
    parameter int W  = NCO_W_DEF,
    parameter int CW = NCO_CW_DEF
) ();

    logic                    in_valid;
    logic signed [W-1:0]     sin_i;
    logic signed [W-1:0]     cos_i;
    logic                    start;
    logic [NCO_NP_W-1:0]     num_periods;
    logic                    busy;
    logic                    done;
    logic [CW-1:0]           period_sum;
    logic signed [W-1:0]     peak_o;
    logic                    quad_err;
    logic                    ovf;

    modport master (
        output in_valid, sin_i, cos_i, start, num_periods,
        input  busy, done, period_sum, peak_o, quad_err, ovf
    );

    modport slave (
        input  in_valid, sin_i, cos_i, start, num_periods,
        output busy, done, period_sum, peak_o, quad_err, ovf
    );

endinterface

// File: rtl/nco_zc_det.sv
// Sine sign history and rising zero-crossing (negative -> non-negative) detector.
module nco_zc_det (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    input  logic sign_i,
    output logic rise
);

    logic sign_q;
    logic hist_vld;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            sign_q   <= 1'b0;
            hist_vld <= 1'b0;
        end else if (en) begin
            sign_q   <= sign_i;
            hist_vld <= 1'b1;
        end
    end

    // A crossing needs a previous sample taken after the last clear.
    assign rise = en & hist_vld & sign_q & ~sign_i;

endmodule

// File: rtl/nco_mon.sv
// NCO output monitor: counts samples over num_periods sine periods, flags quadrature errors.
// Optional peak tracker enabled by defining NCO_MON_PEAK_EN.
module nco_mon
    import nco_pkg::*;
#(
    parameter int W  = NCO_W_DEF,
    parameter int CW = NCO_CW_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     clken,
    nco_mon_if.slave bus
);

    localparam logic [CW-1:0] CNT_FULL = {CW{1'b1}};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_FULL) ? v : v + CW'(1);
    endfunction

    nco_state_t          state;
    nco_state_t          state_nx;
    logic                sample_ev;
    logic                start_acc;
    logic                running;
    logic                rise;
    logic                cos_neg;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_inc;
    logic [NCO_NP_W-1:0] per_cnt;
    logic [NCO_NP_W-1:0] per_inc;
    logic [NCO_NP_W-1:0] np_tgt;
    logic                quad_acc;
    logic                ovf_hit;
    logic                fin_hit;
    logic                enter_done;
    logic [CW-1:0]       period_sum_r;
    logic                quad_err_r;
    logic                ovf_r;

    assign sample_ev = clken & bus.in_valid;
    assign start_acc = clken & bus.start & (state == ST_IDLE);
    assign running   = (state == ST_ARM) | (state == ST_MEASURE);
    assign cos_neg   = bus.cos_i[W-1];
    assign cnt_inc   = sat_inc(cnt);
    assign per_inc   = per_cnt + NCO_NP_W'(1);

    nco_zc_det u_zc (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (sample_ev),
        .clr     (start_acc),
        .sign_i  (bus.sin_i[W-1]),
        .rise    (rise)
    );

    // The arming crossing restarts the counter, so it cannot also overflow it.
    assign ovf_hit    = running & sample_ev & (cnt_inc == CNT_FULL)
                        & ~((state == ST_ARM) & rise);
    assign fin_hit    = (state == ST_MEASURE) & sample_ev & rise & (per_inc == np_tgt);
    assign enter_done = ovf_hit | fin_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clken) begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) state_nx = ST_ARM;
                end
                ST_ARM: begin
                    if (enter_done)            state_nx = ST_DONE;
                    else if (sample_ev && rise) state_nx = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (enter_done) state_nx = ST_DONE;
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt          <= '0;
            per_cnt      <= '0;
            np_tgt       <= '0;
            quad_acc     <= 1'b0;
            period_sum_r <= '0;
            quad_err_r   <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (start_acc) begin
            cnt          <= '0;
            per_cnt      <= '0;
            np_tgt       <= np_target(bus.num_periods);
            quad_acc     <= 1'b0;
            period_sum_r <= '0;
            quad_err_r   <= 1'b0;
            ovf_r        <= 1'b0;
        end else if (running && sample_ev) begin
            cnt <= ((state == ST_ARM) && rise) ? '0 : cnt_inc;
            if ((state == ST_MEASURE) && rise) per_cnt <= per_inc;
            if (rise && cos_neg) quad_acc <= 1'b1;
            // Results include the sample that completes the measurement.
            if (enter_done) begin
                period_sum_r <= ovf_hit ? CNT_FULL : cnt_inc;
                quad_err_r   <= quad_acc | (rise & cos_neg);
                ovf_r        <= ovf_hit;
            end
        end
    end

`ifdef NCO_MON_PEAK_EN
    localparam logic signed [W-1:0] PK_MIN = {1'b1, {(W-1){1'b0}}};

    function automatic logic signed [W-1:0] smax(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic signed [W-1:0] sin_s;
    logic signed [W-1:0] peak_acc;
    logic signed [W-1:0] peak_nx;
    logic signed [W-1:0] peak_r;

    assign sin_s   = bus.sin_i;
    assign peak_nx = smax(peak_acc, sin_s);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            peak_acc <= '0;
            peak_r   <= '0;
        end else if (start_acc) begin
            peak_acc <= PK_MIN;
            peak_r   <= '0;
        end else if (running && sample_ev) begin
            peak_acc <= peak_nx;
            if (enter_done) peak_r <= peak_nx;
        end
    end

    assign bus.peak_o = peak_r;
`else
    assign bus.peak_o = '0;
`endif

    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = (state == ST_DONE);
    assign bus.period_sum = period_sum_r;
    assign bus.quad_err   = quad_err_r;
    assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_nco_mon.sv
// Directed bench for nco_mon: NCO stream model, result scoreboard, immediate assertions.
module tb_nco_mon;

    localparam int  W    = 20;
    localparam int  CW   = 32;
    localparam int  CW8  = 8;
    localparam real PI   = 3.14159265358979323846;
    localparam int  AMP  = 524287;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clken   = 1'b0;

    always #5 clk = ~clk;

    nco_mon_if #(.W(W), .CW(CW))  bus  ();
    nco_mon_if #(.W(W), .CW(CW8)) bus8 ();

    nco_mon #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .bus     (bus)
    );

    nco_mon #(.W(W), .CW(CW8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .clken   (clken),
        .bus     (bus8)
    );

    typedef struct {
        logic [31:0] psum;
        logic        quad;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    int                  errors = 0;
    int                  checks = 0;
    int unsigned         phase = 0;
    int unsigned         phi_inc = 32'h2AAAB;
    logic                swap = 1'b0;
    logic                const_mode = 1'b0;
    logic                tog = 1'b0;
    logic                burst = 1'b0;
    logic                tracking = 1'b0;
    logic signed [W-1:0] pk_model = '0;
    int                  cyc = 0;

    function automatic logic signed [W-1:0] to_smp(input real x);
        int r;
        r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return W'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_sample();
        real th;
        real s;
        real c;
        th = 2.0 * PI * real'(phase) / 1048576.0;
        if (const_mode) begin
            s = 1000.0;
            c = 0.0;
        end else begin
            s = real'(AMP) * $sin(th);
            c = real'(AMP) * $cos(th);
        end
        bus.in_valid  = tog ? ~bus.in_valid : 1'b1;
        bus.sin_i     = to_smp(swap ? c : s);
        bus.cos_i     = to_smp(swap ? s : c);
        bus8.in_valid = bus.in_valid;
        bus8.sin_i    = bus.sin_i;
        bus8.cos_i    = bus.cos_i;
        clken         = burst ? ((cyc % 11) < 7) : 1'b1;
    endtask

    // One clock: the NCO model advances only on consumed samples.
    task automatic tick();
        @(posedge clk);
        if (clken && bus.in_valid) begin
            if (tracking && (bus.sin_i > pk_model)) pk_model = bus.sin_i;
            phase = (phase + phi_inc) & 32'hFFFFF;
        end
        #1;
        cyc++;
        drive_sample();
    endtask

    task automatic run_meas(input string tag, input int np, input int unsigned inc,
                            input logic sw, input logic cmode, input logic tg, input logic bu,
                            input logic use8, input logic [31:0] e_psum, input logic e_quad,
                            input logic e_ovf, input logic pk_fixed,
                            input logic signed [W-1:0] pk_val, input int budget);
        exp_t                e;
        logic                seen;
        logic                busy_ok;
        logic signed [W-1:0] e_pk;
        phi_inc    = inc;
        swap       = sw;
        const_mode = cmode;
        tog        = 1'b0;
        burst      = 1'b0;
        phase      = 0;
        bus.num_periods  = 8'(np);
        bus8.num_periods = 8'(np);
        drive_sample();
        if (use8) bus8.start = 1'b1;
        else      bus.start  = 1'b1;
        e.psum = e_psum;
        e.quad = e_quad;
        e.ovf  = e_ovf;
        sb.push_back(e);
        pk_model = {1'b1, {(W-1){1'b0}}};
        tick();
        bus.start  = 1'b0;
        bus8.start = 1'b0;
        bus.num_periods  = 8'(np + 5);
        bus8.num_periods = 8'(np + 5);
        tracking = 1'b1;
        tog      = tg;
        burst    = bu;
        check({tag, " busy_after_start"}, use8 ? bus8.busy : bus.busy, 1);
        check({tag, " cleared_at_start"},
              use8 ? {bus8.period_sum, bus8.quad_err, bus8.ovf} : {bus.period_sum, bus.quad_err, bus.ovf}, 0);
        seen    = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (use8 ? bus8.done : bus.done) seen = 1'b1;
            else if (!(use8 ? bus8.busy : bus.busy)) busy_ok = 1'b0;
        end
        tracking = 1'b0;
        tog      = 1'b0;
        burst    = 1'b0;
        clken    = 1'b1;
        bus.in_valid  = 1'b1;
        bus8.in_valid = 1'b1;
        check({tag, " done_seen"}, seen, 1);
        check({tag, " busy_held"}, busy_ok, 1);
        e = sb.pop_front();
`ifdef NCO_MON_PEAK_EN
        e_pk = pk_fixed ? pk_val : pk_model;
`else
        e_pk = '0;
`endif
        check({tag, " period_sum"}, use8 ? 32'(bus8.period_sum) : bus.period_sum, e.psum);
        check({tag, " quad_err"}, use8 ? bus8.quad_err : bus.quad_err, e.quad);
        check({tag, " ovf"}, use8 ? bus8.ovf : bus.ovf, e.ovf);
        check({tag, " peak_o"}, use8 ? bus8.peak_o : bus.peak_o, e_pk);
        check({tag, " busy_in_done"}, use8 ? bus8.busy : bus.busy, 1);
        tick();
        check({tag, " done_one_cycle"}, use8 ? bus8.done : bus.done, 0);
        check({tag, " idle_after_done"}, use8 ? bus8.busy : bus.busy, 0);
    endtask

    initial begin
        logic done_seen;
        bus.start        = 1'b0;
        bus8.start       = 1'b0;
        bus.num_periods  = '0;
        bus8.num_periods = '0;
        bus.in_valid     = 1'b0;
        bus8.in_valid    = 1'b0;
        bus.sin_i        = '0;
        bus.cos_i        = '0;
        bus8.sin_i       = '0;
        bus8.cos_i       = '0;
        clken            = 1'b1;
        reset_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst period_sum", bus.period_sum, 0);
        check("rst peak_o", bus.peak_o, 0);
        check("rst quad_err", bus.quad_err, 0);
        check("rst ovf", bus.ovf, 0);
        check("rst8 busy_done", {bus8.busy, bus8.done}, 0);
        check("rst8 results", {bus8.period_sum, bus8.quad_err, bus8.ovf}, 0);
        reset_n = 1'b1;
        drive_sample();
        repeat (3) tick();

        run_meas("np4", 4, 32'h2AAAB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd24, 1'b0, 1'b0, 1'b0, '0, 200);
        run_meas("np0", 0, 32'h2AAAB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0, '0, 100);
        run_meas("swap", 1, 32'h2AAAB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd6, 1'b1, 1'b0, 1'b0, '0, 100);
        run_meas("gaps", 4, 32'h2AAAB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd24, 1'b0, 1'b0, 1'b0, '0, 400);
        run_meas("peak", 2, 32'h40000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 1'b1,
                 20'sh7FFFF, 100);
        run_meas("ovf8", 4, 32'h2AAAB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, '0, 400);

        // Abort a running measurement with reset while the clock enable is low.
        const_mode = 1'b0;
        phi_inc    = 32'h2AAAB;
        phase      = 0;
        bus.num_periods = 8'd4;
        drive_sample();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (12) tick();
        check("abort busy_before", bus.busy, 1);
        reset_n = 1'b0;
        clken   = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort results", {bus.period_sum, bus.quad_err, bus.ovf}, 0);
        check("abort peak_o", bus.peak_o, 0);
        reset_n   = 1'b1;
        drive_sample();
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        check("abort no_done", done_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nco_mon.md
NCO_MON -- requirements
Module: nco_mon

Interface
REQ-001 Parameter W, default 20, sample width of sin/cos inputs (two's complement).
REQ-002 Parameter CW, default 32, width of sample counter and period_sum.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 clken  input  1  clock enable; low freezes all state and outputs.
REQ-006 in_valid  input  1  sample qualifier from NCO (out_valid).
REQ-007 sin_i  input  W  NCO sine sample.
REQ-008 cos_i  input  W  NCO cosine sample.
REQ-009 start  input  1  single-cycle measurement request.
REQ-010 num_periods  input  8  number of sine periods to measure; 0 treated as 1.
REQ-011 busy  output  1  high from accepted start until done.
REQ-012 done  output  1  one-cycle pulse when results update.
REQ-013 period_sum  output  CW  valid samples spanning num_periods full periods.
REQ-014 peak_o  output  W  maximum sin_i seen during measurement.
REQ-015 quad_err  output  1  sticky; cos negative at a sine rising crossing.
REQ-016 ovf  output  1  sample counter saturated; measurement aborted.

Function
REQ-017 Sample event = clken & in_valid on a rising clk edge; only sample events advance counters/sign history.
REQ-018 Rising crossing = previous sample sign bit 1 and current sample sign bit 0, both taken from sample events after start.
REQ-019 FSM states IDLE, ARM, MEASURE, DONE; IDLE->ARM on start, clearing sign history, counters, quad_err, ovf, peak register.
REQ-020 ARM: first sample event only loads sign history; ARM->MEASURE on first rising crossing, sample counter set to 0.
REQ-021 MEASURE: sample counter increments on every sample event; the crossing sample itself counts as sample 1 of the next period.
REQ-022 MEASURE: period counter increments per rising crossing; when it reaches max(num_periods,1), period_sum <= sample count at that crossing, state -> DONE.
REQ-023 num_periods is sampled at start; later changes ignored until next start.
REQ-024 Counter reaching all-ones in ARM or MEASURE -> ovf=1, period_sum=all-ones, state -> DONE.
REQ-025 DONE lasts exactly one cycle: done=1, busy=0 on the following cycle, state -> IDLE.
REQ-026 busy=1 in ARM and MEASURE and during DONE cycle; start while busy is ignored; start in DONE cycle ignored.
REQ-027 quad_err set at any rising crossing (ARM or MEASURE) where cos_i sign bit is 1; held until next accepted start.
REQ-028 period_sum, peak_o, ovf, quad_err are registered and change only at start (clear) or on entering DONE; latency crossing->done is one cycle.
REQ-029 Sign comparisons use MSB only; zero counts as non-negative.

Reset
REQ-030 reset_n low at rising clk: state IDLE, busy=0, done=0, period_sum=0, peak_o=0, quad_err=0, ovf=0, all internal counters/history 0.
REQ-031 Reset during ARM/MEASURE aborts measurement with no done pulse; reset has priority over clken.

Configuration
REQ-032 Macro NCO_MON_PEAK_EN defined: peak register tracks signed maximum of sin_i over ARM+MEASURE sample events, reset to most-negative value at start, copied to peak_o on DONE.
REQ-033 NCO_MON_PEAK_EN undefined: no peak logic synthesized; peak_o tied to 0.

Structure
REQ-034 Shared package nco_pkg holds FSM state enum type, default W/CW constants, and num_periods width constant.
REQ-035 One sub-module nco_zc_det: sign history register plus rising-crossing pulse, enabled by sample event, cleared by start.

Verification
REQ-036 NCO stream phi_inc 0x2AAAB (period 6 samples), num_periods=4, start -> done after 4 crossings, period_sum=24, quad_err=0, ovf=0.
REQ-037 Same stream, num_periods=0 -> period_sum=6, done pulse exactly one cycle.
REQ-038 Stream with sin/cos swapped (cos negative at crossings) -> quad_err=1 at done; new start clears it to 0.
REQ-039 in_valid toggling every other cycle and clken low bursts -> period_sum unchanged (24 for case REQ-036), busy held throughout.
REQ-040 Constant positive sin_i, CW=8 override -> ovf=1, period_sum=0xFF, done pulse, return to IDLE.
REQ-041 reset_n low mid-MEASURE -> all outputs 0 next cycle, no done; with NCO_MON_PEAK_EN, amplitude 0x7FFFF stream gives peak_o=0x7FFFF, without it peak_o=0.
